// File: rtl/csr_access_unit_if.sv
// Request/response handshake and CSR-file bus of the CSR access unit.
// The slave modport is the unit's view; the master modport is the surrounding pipeline/CSR file.
interface csr_access_unit_if;
    // Request channel
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  funct3;
    logic [11:0] csr_num;
    logic [4:0]  rs1_idx;
    logic [31:0] rs1_val;

    // Response channel
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_illegal;

    // CSR file bus
    logic [31:0] csr_addr;
    logic [31:0] csr_wdata;
    logic        csr_we;
    logic [31:0] csr_rdata;

    modport master (
        output req_valid, funct3, csr_num, rs1_idx, rs1_val,
        output resp_ready,
        output csr_rdata,
        input  req_ready,
        input  resp_valid, resp_rdata, resp_illegal,
        input  csr_addr, csr_wdata, csr_we
    );

    modport slave (
        input  req_valid, funct3, csr_num, rs1_idx, rs1_val,
        input  resp_ready,
        input  csr_rdata,
        output req_ready,
        output resp_valid, resp_rdata, resp_illegal,
        output csr_addr, csr_wdata, csr_we
    );
endinterface

// File: rtl/csr_access_unit.sv
// CSR access unit: executes one CSRRW/RS/RC(I) instruction as a read-modify-write
// sequence against an external CSR file with a one-cycle read latency.
module csr_access_unit (
    input  logic              clk,
    input  logic              resetn,
    csr_access_unit_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        CAPT,
        WRITE,
        RESP
    } state_t;

    state_t      state;

    // Request fields frozen at acceptance
    logic [2:0]  op_q;
    logic [11:0] num_q;
    logic [4:0]  idx_q;
    logic [31:0] val_q;

    logic [31:0] src;
    logic [31:0] new_val;
    logic        op_bad;
    logic        wr_intent;
    logic        ro_csr;
    logic        illegal;

    // Operation decode; only meaningful in CAPT, where csr_rdata carries the old value.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        src       = op_q[2] ? {27'd0, idx_q} : val_q;
        new_val   = src;
        wr_intent = 1'b0;
        op_bad    = (op_q[1:0] == 2'b00);
        ro_csr    = (num_q[11:10] == 2'b11);
        case (op_q[1:0])
            2'b01: begin
                new_val   = src;
                wr_intent = 1'b1;
            end
            2'b10: begin
                new_val   = bus.csr_rdata | src;
                wr_intent = (idx_q != 5'd0);
            end
            2'b11: begin
                new_val   = bus.csr_rdata & ~src;
                wr_intent = (idx_q != 5'd0);
            end
            default: begin
                new_val   = src;
                wr_intent = 1'b0;
            end
        endcase
        illegal = op_bad | (wr_intent & ro_csr);
    end

    // Control FSM; all outputs registered so they are glitch-free and clear asynchronously.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state            <= IDLE;
            op_q             <= 3'd0;
            num_q            <= 12'd0;
            idx_q            <= 5'd0;
            val_q            <= 32'd0;
            bus.req_ready    <= 1'b1;
            bus.resp_valid   <= 1'b0;
            bus.resp_illegal <= 1'b0;
            bus.resp_rdata   <= 32'd0;
            bus.csr_addr     <= 32'd0;
            bus.csr_wdata    <= 32'd0;
            bus.csr_we       <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register
            // samples pre-edge values regardless of statement order.
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        op_q          <= bus.funct3;
                        num_q         <= bus.csr_num;
                        idx_q         <= bus.rs1_idx;
                        val_q         <= bus.rs1_val;
                        bus.csr_addr  <= {18'd0, bus.csr_num, 2'b00};
                        bus.req_ready <= 1'b0;
                        state         <= READ;
                    end
                end

                READ: begin
                    state <= CAPT;
                end

                CAPT: begin
                    // Unsupported encodings report zero rather than leaking the CSR contents.
                    bus.resp_rdata   <= op_bad ? 32'd0 : bus.csr_rdata;
                    bus.resp_illegal <= illegal;
                    bus.csr_wdata    <= new_val;
                    if (wr_intent && !illegal) begin
                        bus.csr_we <= 1'b1;
                        state      <= WRITE;
                    end else begin
                        bus.resp_valid <= 1'b1;
                        state          <= RESP;
                    end
                end

                WRITE: begin
                    bus.csr_we     <= 1'b0;
                    bus.resp_valid <= 1'b1;
                    state          <= RESP;
                end

                RESP: begin
                    if (bus.resp_ready) begin
                        bus.resp_valid <= 1'b0;
                        bus.req_ready  <= 1'b1;
                        state          <= IDLE;
                    end
                end

                default: begin
                    bus.csr_we     <= 1'b0;
                    bus.resp_valid <= 1'b0;
                    bus.req_ready  <= 1'b1;
                    state          <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_csr_access_unit.sv
// Directed bench for csr_access_unit: a behavioural CSR file plus a scoreboard of
// expected responses, latencies and write pulses.
module tb_csr_access_unit;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    csr_access_unit_if bus ();

    csr_access_unit dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        illegal;
        logic        wr;
        logic [31:0] wdata;
        logic [31:0] addr;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad   = 0;

    // Behavioural CSR file: one-cycle read latency, write on csr_we
    logic [31:0] csr_mem [0:4095];
    logic [31:0] ref_mem [0:4095];
    logic        pl_en  = 1'b0;
    logic [11:0] pl_num = 12'd0;
    logic [31:0] pl_val = 32'd0;

    always @(posedge clk) begin
        if (pl_en)
            csr_mem[pl_num] <= pl_val;
        else if (bus.csr_we)
            csr_mem[bus.csr_addr[13:2]] <= bus.csr_wdata;
        bus.csr_rdata <= csr_mem[bus.csr_addr[13:2]];
    end

    int          we_cnt = 0;
    logic [31:0] last_wdata = 32'd0;
    logic [31:0] last_waddr = 32'd0;

    always @(negedge clk) begin
        if (bus.csr_we) begin
            we_cnt     = we_cnt + 1;
            last_wdata = bus.csr_wdata;
            last_waddr = bus.csr_addr;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [11:0] num, input logic [31:0] val);
        pl_en  = 1'b1;
        pl_num = num;
        pl_val = val;
        ref_mem[num] = val;
        @(posedge clk);
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    // Issue one request at a negedge, optionally stall the response, then score it.
    task automatic do_req(input logic [2:0] f3, input logic [11:0] num, input logic [4:0] idx,
                          input logic [31:0] val, input int hold);
        exp_t        e;
        logic [31:0] old;
        logic [31:0] src;
        logic        op_bad;
        logic        intent;
        int          lat;
        int          we_before;
        logic [31:0] got_rdata;
        logic        got_ill;

        old       = ref_mem[num];
        src       = f3[2] ? {27'd0, idx} : val;
        op_bad    = (f3 == 3'b000) || (f3 == 3'b100);
        intent    = !op_bad && ((f3[1:0] == 2'b01) || (idx != 5'd0));
        e.illegal = op_bad || (intent && (num[11:10] == 2'b11));
        e.wr      = intent && !e.illegal;
        e.rdata   = op_bad ? 32'd0 : old;
        case (f3[1:0])
            2'b10:   e.wdata = old | src;
            2'b11:   e.wdata = old & ~src;
            default: e.wdata = src;
        endcase
        e.addr = {18'd0, num, 2'b00};
        e.lat  = e.wr ? 4 : 3;
        if (e.wr) ref_mem[num] = e.wdata;
        sb.push_back(e);

        check("req_ready_idle", {31'd0, bus.req_ready}, 32'd1);
        bus.req_valid = 1'b1;
        bus.funct3    = f3;
        bus.csr_num   = num;
        bus.rs1_idx   = idx;
        bus.rs1_val   = val;
        we_before     = we_cnt;

        @(posedge clk);
        lat = 1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        while (!bus.resp_valid && lat < 12) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check("resp_seen", {31'd0, bus.resp_valid}, 32'd1);
        got_rdata = bus.resp_rdata;
        got_ill   = bus.resp_illegal;

        // Stall the consumer while offering a competing request that must be ignored
        for (int i = 0; i < hold; i++) begin
            bus.req_valid = 1'b1;
            bus.funct3    = 3'b001;
            bus.csr_num   = 12'h305;
            bus.rs1_idx   = 5'd7;
            bus.rs1_val   = 32'hBAD0_BAD0;
            @(posedge clk);
            @(negedge clk);
            check("hold_valid", {31'd0, bus.resp_valid}, 32'd1);
            check("hold_rdata", bus.resp_rdata, e.rdata);
            check("hold_illegal", {31'd0, bus.resp_illegal}, {31'd0, e.illegal});
            check("hold_req_ready", {31'd0, bus.req_ready}, 32'd0);
        end
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.resp_ready = 1'b0;
        check("resp_dropped", {31'd0, bus.resp_valid}, 32'd0);
        check("ready_back", {31'd0, bus.req_ready}, 32'd1);

        e = sb.pop_front();
        check("resp_rdata", got_rdata, e.rdata);
        check("resp_illegal", {31'd0, got_ill}, {31'd0, e.illegal});
        check("latency", lat, e.lat);
        check("we_pulses", we_cnt - we_before, e.wr ? 32'd1 : 32'd0);
        check("csr_addr", bus.csr_addr, e.addr);
        if (e.wr) begin
            check("csr_wdata", last_wdata, e.wdata);
            check("write_addr", last_waddr, e.addr);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        logic seen;

        resetn         = 1'b0;
        bus.req_valid  = 1'b0;
        bus.funct3     = 3'd0;
        bus.csr_num    = 12'd0;
        bus.rs1_idx    = 5'd0;
        bus.rs1_val    = 32'd0;
        bus.resp_ready = 1'b0;
        #12;
        check("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        check("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        check("rst_resp_illegal", {31'd0, bus.resp_illegal}, 32'd0);
        check("rst_csr_we", {31'd0, bus.csr_we}, 32'd0);
        check("rst_resp_rdata", bus.resp_rdata, 32'd0);
        check("rst_csr_addr", bus.csr_addr, 32'd0);
        check("rst_csr_wdata", bus.csr_wdata, 32'd0);

        @(negedge clk);
        preload(12'h305, 32'h0000_0000);
        preload(12'h300, 32'h0000_0008);
        preload(12'h304, 32'h0000_00FF);
        preload(12'hF11, 32'h0000_1234);
        preload(12'hC00, 32'h0000_0055);
        preload(12'h340, 32'h0000_00F0);
        preload(12'h341, 32'h0000_FFFF);
        preload(12'h342, 32'h0000_0077);
        preload(12'h306, 32'h0000_0011);

        // Release and accept on the very first rising edge
        resetn = 1'b1;
        do_req(3'b001, 12'h305, 5'd5,  32'h0000_1000, 0);   // CSRRW
        do_req(3'b010, 12'h300, 5'd0,  32'hFFFF_FFFF, 0);   // CSRRS read-only
        do_req(3'b111, 12'h304, 5'h0A, 32'h0000_0000, 0);   // CSRRCI
        do_req(3'b001, 12'hF11, 5'd2,  32'h0000_ABCD, 0);   // write to read-only CSR
        do_req(3'b100, 12'h304, 5'd1,  32'h0000_0001, 0);   // reserved funct3
        do_req(3'b000, 12'h300, 5'd0,  32'h0000_0000, 0);   // reserved funct3
        do_req(3'b010, 12'hC00, 5'd0,  32'h1234_5678, 0);   // read of read-only CSR
        do_req(3'b110, 12'h340, 5'h0F, 32'hFFFF_FFFF, 0);   // CSRRSI
        do_req(3'b011, 12'h341, 5'd9,  32'h0000_0F0F, 0);   // CSRRC
        do_req(3'b101, 12'h342, 5'd0,  32'hFFFF_FFFF, 0);   // CSRRWI zero still writes
        do_req(3'b001, 12'h305, 5'd3,  32'h0000_ABCD, 5);   // back-pressured response

        // Abort an operation while its write strobe is high
        bus.req_valid = 1'b1;
        bus.funct3    = 3'b001;
        bus.csr_num   = 12'h306;
        bus.rs1_idx   = 5'd1;
        bus.rs1_val   = 32'h0000_DEAD;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        n = 0;
        while (!bus.csr_we && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("abort_we_seen", {31'd0, bus.csr_we}, 32'd1);
        #2 resetn = 1'b0;
        #1;
        check("abort_we_async", {31'd0, bus.csr_we}, 32'd0);
        check("abort_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        check("abort_req_ready", {31'd0, bus.req_ready}, 32'd1);
        check("abort_csr_addr", bus.csr_addr, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        seen   = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            seen = seen | bus.resp_valid | bus.csr_we;
        end
        check("abort_no_activity", {31'd0, seen}, 32'd0);
        check("abort_ready_after", {31'd0, bus.req_ready}, 32'd1);
        check("abort_csr_kept", csr_mem[12'h306], 32'h0000_0011);

        do_req(3'b010, 12'h300, 5'd3, 32'h0000_0010, 0);    // CSRRS after abort

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
